// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg : sequencer state encoding, error causes, reset PC       |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_MEM_REQ    = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_WB         = 3'd5,
        S_HALT       = 3'd6,
        S_ERR        = 3'd7
    } state_t;

    localparam logic [1:0] C_ERR_IFETCH   = 2'd0;
    localparam logic [1:0] C_ERR_DATA     = 2'd1;
    localparam logic [1:0] C_ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] C_ERR_MISALIGN = 2'd3;

    localparam logic [63:0] C_RESET_PC = 64'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/core_perf_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_perf_cnt : wrapping cycle and retired-instruction counters   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module core_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_en_i,
    input  logic             ret_inc_i,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (cyc_en_i) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (ret_inc_i) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;

endmodule
`default_nettype wire

// File: rtl/core_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_seq : multi-cycle fetch/exec/mem/writeback sequencer         |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module core_seq
    import core_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(C_RESET_PC),
    parameter int              TIMEOUT  = 1024,
    parameter int              CNT_W    = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [XLEN-1:0]  imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [ILEN-1:0]  imem_rsp_data_i,
    input  logic             imem_rsp_err_i,
    output logic [ILEN-1:0]  inst_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic             halt_i,
    input  logic             mem_en_i,
    input  logic             mem_we_i,
    input  logic             wen_req_i,
    input  logic [XLEN-1:0]  next_pc_i,
    output logic             dmem_req_valid_o,
    output logic             dmem_req_we_o,
    input  logic             dmem_req_ready_i,
    input  logic             dmem_rsp_valid_i,
    input  logic [XLEN-1:0]  dmem_rsp_data_i,
    input  logic             dmem_rsp_err_i,
    output logic [XLEN-1:0]  mem_rdata_o,
    output logic             reg_wen_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] inst_q;
    logic [XLEN-1:0] mem_rdata_q;
    logic            halted_q;
    logic            err_q;

    logic w_in_wait;
    logic w_tmo;
    logic w_misalign;
    logic w_retire;

    assign w_in_wait  = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                        (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);
    assign w_tmo      = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));
    assign w_misalign = |next_pc_i[1:0];
    assign w_retire   = (state_q == S_WB) && !w_misalign;

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            S_FETCH_REQ: begin
                if (imem_req_ready_i) state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (imem_rsp_err_i) begin
                        state_d    = S_ERR;
                        err_code_d = C_ERR_IFETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (halt_i)        state_d = S_HALT;
                else if (mem_en_i) state_d = S_MEM_REQ;
                else               state_d = S_WB;
            end
            S_MEM_REQ: begin
                if (dmem_req_ready_i) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (dmem_rsp_valid_i) begin
                    if (dmem_rsp_err_i) begin
                        state_d    = S_ERR;
                        err_code_d = C_ERR_DATA;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (w_misalign) begin
                    state_d    = S_ERR;
                    err_code_d = C_ERR_MISALIGN;
                end else begin
                    state_d = S_FETCH_REQ;
                end
            end
            default: state_d = state_q;
        endcase
        // A handshake in the expiry cycle has already moved state_d, so it wins.
        if (w_in_wait && (state_d == state_q) && w_tmo) begin
            state_d    = S_ERR;
            err_code_d = C_ERR_TIMEOUT;
        end
        tcnt_d = (w_in_wait && (state_d == state_q)) ? tcnt_q + TW'(1) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_FETCH_REQ;
            err_code_q  <= '0;
            tcnt_q      <= '0;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            mem_rdata_q <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            tcnt_q     <= tcnt_d;
            halted_q   <= (state_d == S_HALT);
            err_q      <= (state_d == S_ERR);
            if ((state_q == S_FETCH_WAIT) && imem_rsp_valid_i && !imem_rsp_err_i) begin
                inst_q <= imem_rsp_data_i;
            end
            if ((state_q == S_MEM_WAIT) && dmem_rsp_valid_i && !dmem_rsp_err_i && !mem_we_i) begin
                mem_rdata_q <= dmem_rsp_data_i;
            end
            if (w_retire) begin
                pc_q <= next_pc_i;
            end
        end
    end

    // Strobes are masked while reset is held so nothing leaks out mid-reset.
    assign imem_req_valid_o = rst_i && (state_q == S_FETCH_REQ);
    assign dmem_req_valid_o = rst_i && (state_q == S_MEM_REQ);
    assign dmem_req_we_o    = dmem_req_valid_o && mem_we_i;
    assign reg_wen_o        = rst_i && w_retire && wen_req_i;
    assign imem_req_addr_o  = pc_q;
    assign pc_o             = pc_q;
    assign inst_o           = inst_q;
    assign mem_rdata_o      = mem_rdata_q;
    assign halted_o         = halted_q;
    assign err_o            = err_q;
    assign err_code_o       = err_code_q;

    core_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_en_i  ((state_q != S_HALT) && (state_q != S_ERR)),
        .ret_inc_i (w_retire),
        .cycle_o   (cycle_o),
        .instret_o (instret_o)
    );

endmodule
`default_nettype wire

// File: doc/core_seq.md
Name: core_seq

Overview:
- Parametrised multi-cycle sequencer for the next-generation NPC core.
- Replaces the implicit one-instruction-per-cycle flow with an explicit FSM: fetch, execute, memory, writeback.
- Instruction and data memories are reached through valid/ready request and response handshakes.
- Owns the PC register, the single-cycle regfile write strobe, halt and error reporting, and cycle/instret counters. IDU and EXE remain combinational around it.

Parameters:
- XLEN, 64, datapath, PC and instruction-data width of the memory ports.
- ILEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC value loaded at reset.
- TIMEOUT, 1024, maximum cycles spent in any single request or wait state; 0 disables the check.
- CNT_W, 64, width of the cycle and instret counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-low.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  fetch request accepted.
- imem_req_addr_o  out  XLEN  fetch address; equals pc_o.
- imem_rsp_valid_i  in  1  fetch response valid.
- imem_rsp_data_i  in  ILEN  fetched instruction.
- imem_rsp_err_i  in  1  fetch bus error, qualified by imem_rsp_valid_i.
- inst_o  out  ILEN  registered current instruction, fed to IDU.
- pc_o  out  XLEN  current PC.
- halt_i  in  1  IDU: instruction is ebreak.
- mem_en_i  in  1  IDU: load or store.
- mem_we_i  in  1  IDU: store.
- wen_req_i  in  1  IDU: instruction writes rd.
- next_pc_i  in  XLEN  EXE: next PC.
- dmem_req_valid_o  out  1  data request valid.
- dmem_req_we_o  out  1  data request is a store.
- dmem_req_ready_i  in  1  data request accepted.
- dmem_rsp_valid_i  in  1  data response valid.
- dmem_rsp_data_i  in  XLEN  load data.
- dmem_rsp_err_i  in  1  data bus error, qualified by dmem_rsp_valid_i.
- mem_rdata_o  out  XLEN  registered load data, fed to the writeback mux.
- reg_wen_o  out  1  regfile write strobe.
- halted_o  out  1  sticky halt flag.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  error cause: 0 ifetch bus, 1 data bus, 2 timeout, 3 misaligned PC.
- cycle_o  out  CNT_W  cycle counter.
- instret_o  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset, sampled on posedge with rst_i=0:
  - State = FETCH_REQ, pc_o = RESET_PC.
  - inst_o, mem_rdata_o, counters, err_code_o and the timeout counter all 0.
  - Every valid, reg_wen_o, halted_o and err_o = 0.
  - Reset mid-handshake abandons any outstanding transaction; a stale response arriving afterwards is ignored unless the FSM is in the matching WAIT state.
- States and transitions:
  - FETCH_REQ: imem_req_valid_o=1, held with a stable address until imem_req_ready_i; then go to FETCH_WAIT.
  - FETCH_WAIT: on imem_rsp_valid_i, latch inst_o and go to EXEC; if imem_rsp_err_i is also set, go to ERR with code 0 instead.
  - EXEC: exactly one cycle.
    - halt_i set: go to HALT.
    - else mem_en_i set: go to MEM_REQ.
    - else: go to WB.
  - MEM_REQ: dmem_req_valid_o=1 and dmem_req_we_o=mem_we_i, held until dmem_req_ready_i; then go to MEM_WAIT.
  - MEM_WAIT: on dmem_rsp_valid_i, latch mem_rdata_o (loads only) and go to WB; on dmem_rsp_err_i, go to ERR with code 1.
  - WB: one cycle.
    - reg_wen_o = wen_req_i; reg_wen_o is 0 in every other state.
    - next_pc_i[1:0] != 0: go to ERR with code 3; pc_o, instret and the register write are suppressed (reg_wen_o = 0).
    - otherwise: pc_o <= next_pc_i, instret +1, go to FETCH_REQ.
  - HALT and ERR are terminal until reset. All valids 0, pc_o frozen, both counters frozen.
    - HALT sets halted_o=1.
    - ERR sets err_o=1 and err_code_o.
- Response sampling: imem_rsp_valid_i is ignored outside FETCH_WAIT and dmem_rsp_valid_i outside MEM_WAIT. The memories respond no earlier than one cycle after the request is accepted.
- Timeout:
  - A counter clears on every state change and increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - When it reaches TIMEOUT-1 with no exit condition, the next state is ERR with code 2.
  - A response or ready arriving in that same cycle takes priority over the timeout.
- Counters:
  - cycle_o increments every non-reset cycle outside HALT/ERR.
  - Both counters wrap modulo 2^CNT_W.
- Latency with zero-wait memory (ready in the request cycle, response one cycle later): non-memory instruction 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB); load or store 6 cycles.

Decomposition:
- Shared package, core_pkg:
  - state enum: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
  - err_code constants.
  - RESET_PC default.
- Sub-module core_perf_cnt: the cycle/instret pair, with enable and increment inputs.
- FSM, PC register and timeout counter stay in core_seq.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles -> pc_o=0x8000_0000, all valids/strobes 0, cycle_o=0; first cycle after release imem_req_valid_o=1 with addr 0x8000_0000.
- Back-to-back ALU instructions, zero-wait imem, next_pc=pc+4 -> reg_wen_o pulses once every 4 cycles; after 3 instructions pc_o=0x8000_000C, instret_o=3, cycle_o=12.
- Load with backpressure: dmem_req_ready_i low for 5 cycles, response data 0xDEAD_BEEF -> request held stable, mem_rdata_o=0xDEAD_BEEF at WB, instruction latency 11 cycles.
- Timeout with TIMEOUT=8: imem never responds -> err_o=1 and err_code_o=2 exactly 8 cycles after entering FETCH_WAIT; counters frozen afterwards.
- ebreak: halt_i in EXEC -> halted_o=1, reg_wen_o never asserted, instret_o unchanged, no further requests.
- Misaligned next_pc=0x8000_0002 -> err_code_o=3, pc_o unchanged; reset asserted during MEM_WAIT -> FSM in FETCH_REQ at RESET_PC, and a late dmem response is ignored.
